// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I ALU issue stage: decode, operand forwarding, 2-entry skid-buffered output
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] lhs,
    output logic [31:0] rhs,
    output logic [3:0]  funct,
    output logic [4:0]  rd,
    output logic        wb_en,
    output logic        illegal
);

    localparam logic [3:0] F_AND  = 4'b0000;
    localparam logic [3:0] F_OR   = 4'b0001;
    localparam logic [3:0] F_XOR  = 4'b0010;
    localparam logic [3:0] F_ADD  = 4'b0011;
    localparam logic [3:0] F_SUB  = 4'b1011;
    localparam logic [3:0] F_SRL  = 4'b0100;
    localparam logic [3:0] F_SRA  = 4'b1100;
    localparam logic [3:0] F_SLL  = 4'b0101;
    localparam logic [3:0] F_SLTU = 4'b0110;
    localparam logic [3:0] F_SLT  = 4'b1110;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic        wb_en;
        logic        illegal;
    } beat_t;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [3:0]  base_funct;
    logic        legal;
    beat_t       dec;

    assign opcode  = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_u   = {instr[31:12], 12'b0};

    function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf_val,
                                            input logic fv, input logic [4:0] frd,
                                            input logic [31:0] fdata);
        if (idx == 5'd0)
            return 32'd0;
        else if (fv && frd == idx)
            return fdata;
        else
            return rf_val;
    endfunction

    assign op1 = resolve(rs1_idx, rs1_val, fwd_valid, fwd_rd, fwd_data);
    assign op2 = resolve(rs2_idx, rs2_val, fwd_valid, fwd_rd, fwd_data);

    always_comb begin
        base_funct = F_AND;
        case (f3)
            3'b000:  base_funct = F_ADD;
            3'b001:  base_funct = F_SLL;
            3'b010:  base_funct = F_SLT;
            3'b011:  base_funct = F_SLTU;
            3'b100:  base_funct = F_XOR;
            3'b101:  base_funct = F_SRL;
            3'b110:  base_funct = F_OR;
            default: base_funct = F_AND;
        endcase
    end

    always_comb begin
        dec       = '0;
        legal     = 1'b0;
        dec.rd    = instr[11:7];
        case (opcode)
            OPC_OP: begin
                legal     = (f7 == F7_ZERO) ||
                            (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
                dec.lhs   = op1;
                dec.rhs   = op2;
                dec.funct = base_funct;
                if (instr[30] && f3 == 3'b000)
                    dec.funct = F_SUB;
                if (instr[30] && f3 == 3'b101)
                    dec.funct = F_SRA;
            end
            OPC_OPIMM: begin
                if (f3 == 3'b001)
                    legal = (f7 == F7_ZERO);
                else if (f3 == 3'b101)
                    legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
                else
                    legal = 1'b1;
                dec.lhs   = op1;
                dec.rhs   = imm_i;
                dec.funct = base_funct;
                // Only shifts use instr[30]; an addi immediate never turns into SUB.
                if (instr[30] && f3 == 3'b101)
                    dec.funct = F_SRA;
            end
            OPC_LUI: begin
                legal     = 1'b1;
                dec.lhs   = 32'd0;
                dec.rhs   = imm_u;
                dec.funct = F_ADD;
            end
            OPC_AUIPC: begin
                legal     = 1'b1;
                dec.lhs   = pc;
                dec.rhs   = imm_u;
                dec.funct = F_ADD;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.lhs   = 32'd0;
            dec.rhs   = 32'd0;
            dec.funct = F_AND;
        end
        dec.illegal = !legal;
        dec.wb_en   = legal && (instr[11:7] != 5'd0);
    end

    beat_t main_q;
    beat_t skid_q;
    logic  main_v;
    logic  skid_v;
    logic  accept;
    logic  issue;

    assign accept = in_valid && in_ready && !flush;
    assign issue  = main_v && out_ready;

    // in_ready is only ever 1 while the skid entry is empty, so an accept never overwrites skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            in_ready <= 1'b0;
        end else if (flush) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            in_ready <= 1'b1;
        end else if (!main_v || issue) begin
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                if (accept) begin
                    skid_q   <= dec;
                    skid_v   <= 1'b1;
                    in_ready <= 1'b0;
                end else begin
                    skid_v   <= 1'b0;
                    in_ready <= 1'b1;
                end
            end else begin
                if (accept)
                    main_q <= dec;
                main_v   <= accept;
                in_ready <= 1'b1;
            end
        end else begin
            if (accept) begin
                skid_q   <= dec;
                skid_v   <= 1'b1;
                in_ready <= 1'b0;
            end else begin
                in_ready <= !skid_v;
            end
        end
    end

    assign out_valid = main_v;
    assign lhs       = main_q.lhs;
    assign rhs       = main_q.rhs;
    assign funct     = main_q.funct;
    assign rd        = main_q.rd;
    assign wb_en     = main_q.wb_en;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue
module tb_alu_issue;

    typedef struct packed {
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic        wb_en;
        logic        illegal;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] instr = 0;
    logic [31:0] pc = 0;
    logic [31:0] rs1_val = 0;
    logic [31:0] rs2_val = 0;
    logic        fwd_valid = 0;
    logic [4:0]  fwd_rd = 0;
    logic [31:0] fwd_data = 0;
    logic        flush = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [3:0]  funct;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    alu_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .lhs(lhs), .rhs(rhs), .funct(funct), .rd(rd), .wb_en(wb_en), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rdi, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rdi, op};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rdi);
        return {imm, rs1, f3, rdi, 7'b0010011};
    endfunction

    function automatic exp_t mk(input logic [31:0] l, input logic [31:0] r, input logic [3:0] f,
                                input logic [4:0] d, input logic w, input logic il);
        exp_t e;
        e.lhs = l; e.rhs = r; e.funct = f; e.rd = d; e.wb_en = w; e.illegal = il;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every issued beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t got;
            exp_t e;
            got = {lhs, rhs, funct, rd, wb_en, illegal};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got lhs=%h rhs=%h funct=%b rd=%0d required no beat",
                         lhs, rhs, funct, rd);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL beat: got lhs=%h rhs=%h funct=%b rd=%0d wb=%b ill=%b required lhs=%h rhs=%h funct=%b rd=%0d wb=%b ill=%b",
                             lhs, rhs, funct, rd, wb_en, illegal,
                             e.lhs, e.rhs, e.funct, e.rd, e.wb_en, e.illegal);
                end
            end
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
        int n;
        n = 0;
        in_valid = 1; instr = i; pc = p; rs1_val = a; rs2_val = b;
        forever begin
            @(negedge clk);
            if (in_ready && !flush) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got in_ready=0 required 1");
                in_valid = 0;
                return;
            end
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        out_ready = 1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    localparam logic [6:0] OP = 7'b0110011;

    initial begin
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_lhs", lhs, 0);
        @(posedge clk); #1;
        rst = 0;
        check("rst_release_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        check("in_ready_rise", in_ready, 1);

        out_ready = 1;
        send(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OP), 0, 5, 7, mk(5, 7, 4'b0011, 3, 1, 0));
        send(r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd3, OP), 0, 5, 7, mk(5, 7, 4'b1011, 3, 1, 0));
        send(i_type(12'h403, 5'd1, 3'b101, 5'd4), 0, 32'h80, 0, mk(32'h80, 32'h403, 4'b1100, 4, 1, 0));
        send({20'h12345, 5'd5, 7'b0010111}, 32'h100, 0, 0, mk(32'h100, 32'h12345000, 4'b0011, 5, 1, 0));
        send({20'hFFFFF, 5'd8, 7'b0110111}, 0, 9, 9, mk(0, 32'hFFFFF000, 4'b0011, 8, 1, 0));
        send(i_type(12'hFFF, 5'd1, 3'b000, 5'd9), 0, 3, 0, mk(3, 32'hFFFFFFFF, 4'b0011, 9, 1, 0));
        send(i_type(12'h400, 5'd1, 3'b000, 5'd0), 0, 3, 0, mk(3, 32'h400, 4'b0011, 0, 0, 0));
        send(r_type(7'h00, 5'd2, 5'd1, 3'b010, 5'd10, OP), 0, 1, 2, mk(1, 2, 4'b1110, 10, 1, 0));

        fwd_valid = 1; fwd_rd = 1; fwd_data = 32'hAA;
        send(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd6, OP), 0, 32'h11, 7, mk(32'hAA, 7, 4'b0011, 6, 1, 0));
        fwd_rd = 0;
        send(r_type(7'h00, 5'd2, 5'd0, 3'b000, 5'd7, OP), 0, 32'h11, 7, mk(0, 7, 4'b0011, 7, 1, 0));
        fwd_valid = 0;

        send(r_type(7'h20, 5'd2, 5'd1, 3'b111, 5'd3, OP), 0, 5, 7, mk(0, 0, 4'b0000, 3, 0, 1));
        send(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b1100011), 0, 5, 7, mk(0, 0, 4'b0000, 3, 0, 1));
        send(i_type(12'h203, 5'd1, 3'b001, 5'd4), 0, 5, 0, mk(0, 0, 4'b0000, 4, 0, 1));
        drain();

        // Backpressure: A in main, B in skid, C stalls until released.
        out_ready = 0;
        send(r_type(7'h00, 5'd2, 5'd1, 3'b100, 5'd11, OP), 0, 32'hA, 1, mk(32'hA, 1, 4'b0010, 11, 1, 0));
        send(r_type(7'h00, 5'd2, 5'd1, 3'b110, 5'd12, OP), 0, 32'hB, 2, mk(32'hB, 2, 4'b0001, 12, 1, 0));
        check("skid_full_in_ready", in_ready, 0);
        fork
            send(r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd13, OP), 0, 32'hC, 3, mk(32'hC, 3, 4'b0000, 13, 1, 0));
            begin
                repeat (3) @(posedge clk);
                #1;
                check("held_out_valid", out_valid, 1);
                check("held_lhs", lhs, 32'hA);
                check("held_in_ready", in_ready, 0);
                out_ready = 1;
            end
        join
        drain();

        // Flush with both entries full and a beat presented in the flush cycle.
        out_ready = 0;
        send(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd14, OP), 0, 1, 1, mk(1, 1, 4'b0011, 14, 1, 0));
        send(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd15, OP), 0, 2, 2, mk(2, 2, 4'b0011, 15, 1, 0));
        exp_q.delete();
        in_valid = 1; instr = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd16, OP);
        flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1;
        repeat (4) @(posedge clk);
        #1;

        // Reset pulse mid-stream.
        out_ready = 0;
        send(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd17, OP), 0, 4, 4, mk(4, 4, 4'b0011, 17, 1, 0));
        send(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd18, OP), 0, 5, 5, mk(5, 5, 4'b0011, 18, 1, 0));
        #2;
        rst = 1;
        exp_q.delete();
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 0);
        check("rst_mid_rhs", rhs, 0);
        check("rst_mid_rd", rd, 0);
        @(posedge clk); #1;
        rst = 0;
        check("rst_mid_release_low", in_ready, 0);
        @(posedge clk); #1;
        check("rst_mid_in_ready_rise", in_ready, 1);
        check("rst_mid_still_empty", out_valid, 0);

        out_ready = 1;
        send(r_type(7'h00, 5'd2, 5'd1, 3'b001, 5'd19, OP), 0, 6, 2, mk(6, 2, 4'b0101, 19, 1, 0));
        drain();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-issue stage sitting directly in front of the 4-bit-funct ALU. Accepts a decoded-in-flight RV32I integer instruction with its register-file read values, resolves operand forwarding, and builds the ALU operands `lhs`/`rhs` and the 4-bit ALU function code. Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so `in_ready` is a flop output.

## Interface
- No parameters. Data width is fixed at 32, register index width at 5.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: the upstream beat is valid.
- `in_ready` out 1: the stage can accept a beat (registered).
- `instr` in 32: raw instruction word.
- `pc` in 32: PC of `instr`.
- `rs1_val`, `rs2_val` in 32: register-file read data for `instr[19:15]` and `instr[24:20]`.
- `fwd_valid` in 1: the forwarding source is live.
- `fwd_rd` in 5: destination of the forwarding source.
- `fwd_data` in 32: result of the forwarding source.
- `flush` in 1: synchronous kill of all held beats.
- `out_valid` out 1: the issued beat is valid.
- `out_ready` in 1: the ALU/EX consumer accepts the beat.
- `lhs`, `rhs` out 32: ALU operands.
- `funct` out 4: ALU function code.
- `rd` out 5: destination register.
- `wb_en` out 1: the result is to be written back.
- `illegal` out 1: the instruction is not a supported ALU instruction.

## Operation
- Function code: bit3 selects the alternate form; bits[2:0] select the operation.
  - AND = 0000, OR = 0001, XOR = 0010, ADD = 0011, SUB = 1011.
  - SRL = 0100, SRA = 1100, SLL = 0101, SLTU = 0110, SLT = 1110.
- Mapping from funct3:
  - 000 → ADD. In OP (0110011) it becomes SUB when `instr[30]` is set.
  - 001 → SLL.
  - 010 → SLT.
  - 011 → SLTU.
  - 100 → XOR.
  - 101 → SRL, or SRA when `instr[30]` is set.
  - 110 → OR.
  - 111 → AND.
- OP (0110011): `lhs` = rs1, `rhs` = rs2.
  - Legal funct7 is 0000000, or 0100000 only with funct3 000 or 101.
- OP-IMM (0010011): `lhs` = rs1, `rhs` = sign-extended `instr[31:20]`.
  - For funct3 001, `instr[31:25]` must be 0000000.
  - For funct3 101, `instr[31:25]` must be 0000000 or 0100000.
  - `instr[30]` never selects SUB in OP-IMM.
- LUI (0110111): `lhs` = 0, `rhs` = {`instr[31:12]`, 12'b0}, funct ADD.
- AUIPC (0010111): `lhs` = `pc`, `rhs` = U-immediate, funct ADD.
- Any other opcode or illegal funct7:
  - `illegal` = 1, `wb_en` = 0, `funct` = 0000, `lhs` = `rhs` = 0.
  - The beat still flows through the handshake.
- `rd` = `instr[11:7]`. `wb_en` = legal AND `rd` != 0.
- Operand resolution for rs1 and rs2 independently:
  - Index 0 gives 0.
  - Else, if `fwd_valid` and `fwd_rd` equals the index, gives `fwd_data`.
  - Else gives `rs*_val`.
  - Operands are resolved once, at acceptance. A held beat is never re-resolved; ordering of later writebacks is the hazard unit's responsibility.

## Timing
- Reset:
  - While `rst` is high: `out_valid` = 0, `in_ready` = 0, `lhs`/`rhs`/`funct`/`rd`/`wb_en`/`illegal` = 0, both entries empty.
  - `in_ready` rises on the first rising edge after `rst` deasserts.
  - Reset asserted mid-transfer drops every held beat immediately.
- A beat is accepted on an edge with `in_valid && in_ready && !flush`.
- A beat is issued on an edge with `out_valid && out_ready`.
- Latency: an accepted beat appears on the outputs the next cycle when the main entry is empty or being issued on the same edge.
- Main entry occupied and not issued: the accepted beat goes to the skid entry, and `in_ready` is 0 from the next cycle.
- Skid full and main issued: skid moves to main and `in_ready` returns to 1 the next cycle.
- Order is strictly FIFO. Throughput is one beat per cycle with `out_ready` held at 1.
- Outputs are held stable while `out_valid && !out_ready`.
- `flush` (takes priority over accept and issue):
  - Empties both entries on that edge.
  - `out_valid` = 0 and `in_ready` = 1 next cycle.
  - A beat presented in the flush cycle is discarded.

## Test plan
- ADD issue: OP `add x3,x1,x2` with rs1 = 5, rs2 = 7, `out_ready` = 1 → next cycle `lhs` = 5, `rhs` = 7, `funct` = 0011, `rd` = 3, `wb_en` = 1. With funct7 0100000 → `funct` = 1011.
- SRAI and AUIPC:
  - `srai x4,x1,3` → `funct` = 1100, `rhs` = 0x403 (the immediate field is sign-extended and includes `instr[30]`).
  - `auipc x5,0x12345` at `pc` = 0x100 → `lhs` = 0x100, `rhs` = 0x12345000, `funct` = 0011.
- Forwarding and x0:
  - `fwd_valid` = 1, `fwd_rd` = 1, `fwd_data` = 0xAA, rs1 = x1 with `rs1_val` = 0x11 → `lhs` = 0xAA.
  - rs1 = x0 with `fwd_rd` = 0 and `rs1_val` = 0x11 → `lhs` = 0.
- Backpressure: stream beats A, B, C with `out_ready` = 0 → A on the outputs, B in skid, `in_ready` falls. Release `out_ready` → A, B, C issued in order with no loss or duplication.
- Illegal instruction: funct7 0100000 with funct3 111 in OP → `illegal` = 1, `wb_en` = 0, `funct` = 0000. Opcode 1100011 → same.
- Flush and reset:
  - `flush` with both entries full and `in_valid` = 1 → `out_valid` = 0 and `in_ready` = 1 next cycle, and the flush-cycle beat is never issued.
  - `rst` pulse mid-stream → all outputs 0 immediately, and `in_ready` rises one edge after deassertion.
